// File: rtl/lcd_reg_scanner_if.sv
// Byte stream from the register scanner to the LCD controller.
// The scanner offers a byte with char_valid; the controller takes it with char_ready.
interface lcd_reg_scanner_if;
    logic [7:0] char_data;
    logic       char_is_cmd;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_data,
        output char_is_cmd,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_data,
        input  char_is_cmd,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/lcd_reg_scanner.sv
// LCD register-file viewer: walks the core's debug register index, captures each
// register, prints "Rnn:XXXXXXXX" after a cursor-home command, holds the line on
// screen for a while, then moves to the next register.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | stopped, nothing offered to the LCD
// S_SELECT | reg_no stable, waiting READ_LAT cycles for the core's read data
// S_HOME   | offering the cursor-home command (DDRAM address 0)
// S_CHARS  | offering the 12 line characters, one per accepted transfer
// S_DWELL  | line on screen; index advances when the dwell runs out
module lcd_reg_scanner #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned FIRST_REG    = 0,
    parameter int unsigned LAST_REG     = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic [4:0]          reg_no,
    input  logic [31:0]         reg_content,
    output logic                busy,
    lcd_reg_scanner_if.master   lcd
);

    // One down-counter serves both the read wait and the dwell; they never overlap.
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > READ_LAT) ? DWELL_CYCLES : READ_LAT;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [7:0]  CMD_HOME = 8'h80;
    localparam logic [3:0]  LAST_IDX = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_HOME,
        S_CHARS,
        S_DWELL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic [31:0]        value;
    logic [3:0]         idx;
    logic               xfer;
    logic [1:0]         tens;
    logic [4:0]         tens_sub;
    logic [7:0]         tens_ascii;
    logic [7:0]         units_ascii;
    logic [3:0]         nib;
    logic [7:0]         char_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    assign xfer     = lcd.char_valid && lcd.char_ready;
    assign cnt_zero = (cnt == '0);
    assign busy     = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a line, once started, always runs to the end of its dwell.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable)                    state_nxt = S_SELECT;
            S_SELECT: if (cnt_zero)                  state_nxt = S_HOME;
            S_HOME:   if (xfer)                      state_nxt = S_CHARS;
            S_CHARS:  if (xfer && idx == LAST_IDX)   state_nxt = S_DWELL;
            S_DWELL:  if (cnt_zero)                  state_nxt = enable ? S_SELECT : S_IDLE;
            default:                                 state_nxt = S_IDLE;
        endcase
    end

    // Shared timer: loaded on entry to SELECT or DWELL, counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state != S_SELECT && state_nxt == S_SELECT) begin
            cnt <= CNT_W'(READ_LAT - 1);
        end else if (state != S_DWELL && state_nxt == S_DWELL) begin
            cnt <= CNT_W'(DWELL_CYCLES - 1);
        end else if ((state == S_SELECT || state == S_DWELL) && !cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Register value is sampled once, at the end of the read wait, and held for the line.
    always_ff @(posedge clk) begin
        if (reset)                             value <= '0;
        else if (state == S_SELECT && cnt_zero) value <= reg_content;
    end

    // Character index within the line, advanced only by accepted transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (state == S_CHARS && xfer) begin
            idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
        end
    end

    // Register index advances when the dwell expires, wrapping at LAST_REG.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_no <= 5'(FIRST_REG);
        end else if (state == S_DWELL && cnt_zero) begin
            reg_no <= (reg_no == 5'(LAST_REG)) ? 5'(FIRST_REG) : reg_no + 5'd1;
        end
    end

    // Decimal split of reg_no (0..31) by range compare instead of a divider.
    always_comb begin
        tens     = 2'd0;
        tens_sub = 5'd0;
        if (reg_no >= 5'd30) begin
            tens     = 2'd3;
            tens_sub = 5'd30;
        end else if (reg_no >= 5'd20) begin
            tens     = 2'd2;
            tens_sub = 5'd20;
        end else if (reg_no >= 5'd10) begin
            tens     = 2'd1;
            tens_sub = 5'd10;
        end
        tens_ascii  = 8'h30 + {6'b0, tens};
        units_ascii = 8'h30 + {3'b0, reg_no - tens_sub};
    end

    // Character for the current index: "R", two digits, ":", then hex MSB nibble first.
    always_comb begin
        nib = 4'd0;
        case (idx)
            4'd4:    nib = value[31:28];
            4'd5:    nib = value[27:24];
            4'd6:    nib = value[23:20];
            4'd7:    nib = value[19:16];
            4'd8:    nib = value[15:12];
            4'd9:    nib = value[11:8];
            4'd10:   nib = value[7:4];
            4'd11:   nib = value[3:0];
            default: nib = 4'd0;
        endcase
        case (idx)
            4'd0:    char_byte = 8'h52;
            4'd1:    char_byte = tens_ascii;
            4'd2:    char_byte = units_ascii;
            4'd3:    char_byte = 8'h3A;
            default: char_byte = hex_ascii(nib);
        endcase
    end

    // Byte offer follows the state directly, so data stays put while a transfer stalls.
    always_comb begin
        lcd.char_valid  = 1'b0;
        lcd.char_is_cmd = 1'b0;
        lcd.char_data   = 8'h00;
        case (state)
            S_HOME: begin
                lcd.char_valid  = 1'b1;
                lcd.char_is_cmd = 1'b1;
                lcd.char_data   = CMD_HOME;
            end
            S_CHARS: begin
                lcd.char_valid  = 1'b1;
                lcd.char_data   = char_byte;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_reg_scanner.sv
// Bench for lcd_reg_scanner: a register-file model answers reg_no, expected LCD
// bytes are queued per line and compared as the scanner hands them over.
module tb_lcd_reg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  reg_no;
    logic [31:0] reg_content;
    logic        busy;
    logic [31:0] rf [32];

    lcd_reg_scanner_if lcd_bus ();

    lcd_reg_scanner #(
        .DWELL_CYCLES (4),
        .READ_LAT     (3),
        .FIRST_REG    (0),
        .LAST_REG     (31)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .reg_no      (reg_no),
        .reg_content (reg_content),
        .busy        (busy),
        .lcd         (lcd_bus)
    );

    always #5 clk = ~clk;

    assign reg_content = rf[reg_no];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         xfer_cnt = 0;
    logic [8:0] exp_q [$];
    logic       rmode    = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_byte  = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9) return 8'd48 + 8'(n);
        return 8'd65 + 8'(n) - 8'd10;
    endfunction

    task automatic push_line(input int r, input logic [31:0] v);
        exp_q.push_back({1'b1, 8'h80});
        exp_q.push_back({1'b0, 8'h52});
        exp_q.push_back({1'b0, 8'(48 + r / 10)});
        exp_q.push_back({1'b0, 8'(48 + r % 10)});
        exp_q.push_back({1'b0, 8'h3A});
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back({1'b0, hex_char(v[i*4 +: 4])});
        end
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (xfer_cnt < target) check_val("xfer_timeout", xfer_cnt, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) check_val("idle_timeout", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"},  lcd_bus.char_valid, 0);
        check_val({tag, "_data"},   lcd_bus.char_data, 0);
        check_val({tag, "_is_cmd"}, lcd_bus.char_is_cmd, 0);
        check_val({tag, "_busy"},   busy, 0);
        check_val({tag, "_reg_no"}, reg_no, 0);
    endtask

    // Ready pattern: always ready, or ready one cycle in three.
    initial begin
        int k = 0;
        lcd_bus.char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            lcd_bus.char_ready = rmode ? (k % 3 == 0) : 1'b1;
        end
    end

    // Transfer monitor: scoreboard compare plus hold-while-stalled checks.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", lcd_bus.char_valid, 1);
                check_val("hold_byte", {lcd_bus.char_is_cmd, lcd_bus.char_data}, prev_byte);
            end
            if (lcd_bus.char_valid && lcd_bus.char_ready) begin
                if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
                else check_val("lcd_byte", {lcd_bus.char_is_cmd, lcd_bus.char_data}, exp_q.pop_front());
                xfer_cnt++;
            end
            prev_stall = lcd_bus.char_valid && !lcd_bus.char_ready;
            prev_byte  = {lcd_bus.char_is_cmd, lcd_bus.char_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, xfer_cnt %0d", xfer_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_dropped;
        for (int i = 0; i < 32; i++) rf[i] = $urandom();
        rf[5] = 32'hDEADBEEF;
        reset  = 1'b1;
        enable = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");

        // Lines 0..7; ready throttled on lines 3 and 4; stop requested inside line 7.
        for (int r = 0; r <= 7; r++) push_line(r, rf[r]);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_xfer(39, 400);
        rmode = 1'b1;
        wait_xfer(65, 400);
        rmode = 1'b0;
        wait_xfer(96, 400);
        enable = 1'b0;
        wait_idle(200);
        check_val("stop_reg_no", reg_no, 8);
        check_val("stop_xfer_cnt", xfer_cnt, 104);
        check_val("stop_queue", exp_q.size(), 0);

        // Capture timing on reg 8: only the value present at the third edge after SELECT shows.
        rf[8] = 32'h0BAD0001;
        push_line(8, 32'hC0FFEE42);
        for (int r = 9; r <= 31; r++) push_line(r, rf[r]);
        push_line(0, rf[0]);
        push_line(1, rf[1]);
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rf[8] = 32'h0BAD0002;
        @(posedge clk);
        #1 rf[8] = 32'hC0FFEE42;
        @(posedge clk);
        #1 rf[8] = 32'h0BAD0003;
        @(posedge clk);
        #1 rf[8] = 32'h0BAD0004;

        // Stop requested in line 20, cancelled during its dwell: busy must never drop.
        wait_xfer(265, 600);
        enable = 1'b0;
        wait_xfer(273, 200);
        @(posedge clk);
        #1 enable = 1'b1;
        busy_dropped = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_dropped = 1'b1;
        end
        check_val("stop_cancel_busy", busy_dropped, 0);

        // Run through 30, 31 and the wrap to 0, stop inside line 1.
        wait_xfer(434, 1000);
        enable = 1'b0;
        wait_idle(200);
        check_val("wrap_reg_no", reg_no, 2);
        check_val("wrap_xfer_cnt", xfer_cnt, 442);
        check_val("wrap_queue", exp_q.size(), 0);

        // Reset held three cycles in the middle of a line.
        push_line(2, rf[2]);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_xfer(448, 200);
        @(posedge clk);
        #1 begin
            reset  = 1'b1;
            enable = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (5) @(negedge clk);
        check_val("mid_reset_stays_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
